ifft_frame_ctrl: RTL and testbench
==================================

Name: ifft_frame_ctrl

Overview:
- Sequences whole OFDM packets through the 64-point pipelined IFFT.
- Accepts frequency-domain samples from the mapper over a valid/ready stream and drives the IFFT's clock-enable, synchronous reset and sample inputs.
- Flushes the pipeline with zero samples after the last symbol so every symbol comes out.
- Presents the time-domain result downstream with valid/ready, first-of-symbol and end-of-packet flags, using a global-CE stall.

Parameters:
- LGN, 6, log2 of the FFT size; N = 2**LGN samples per symbol.
- DW, 16, width of each real/imag component; a sample is 2*DW bits, real in the upper half.
- SCW, 8, symbol counter width; a packet holds at most 2**SCW-1 symbols.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_abort  in  1  synchronous packet abort, active high.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream sample accepted when s_valid&s_ready.
- s_data  in  2*DW  frequency-domain sample.
- s_last  in  1  marks the final sample of the packet.
- o_ifft_reset  out  1  synchronous active-high reset to the IFFT.
- o_ifft_ce  out  1  IFFT clock enable.
- o_ifft_sample  out  2*DW  IFFT input sample.
- i_ifft_result  in  2*DW  IFFT output, which holds while ce=0.
- i_ifft_sync  in  1  IFFT first-sample-of-frame flag.
- m_valid  out  1  downstream sample valid.
- m_ready  in  1  downstream accept.
- m_data  out  2*DW  equals i_ifft_result.
- m_first  out  1  first sample of each output symbol.
- m_last  out  1  final sample of the packet.
- o_busy  out  1  state != IDLE.
- o_err_partial  out  1  one-cycle pulse when s_last arrives with the in-symbol index != N-1.

Behaviour:
- Async reset (i_reset_n=0) values:
  - state=IDLE; all counters 0.
  - s_ready=0, o_ifft_ce=0, o_ifft_reset=0, m_valid=0, m_first=0, m_last=0, o_busy=0, o_err_partial=0.
- States:
  - IDLE:
    - s_ready=0.
    - On s_valid: pulse o_ifft_reset=1 for exactly one cycle, zero all counters, go to RUN.
  - RUN:
    - Stall rule: adv = !m_valid | m_ready.
    - s_ready = adv; o_ifft_ce = s_valid & adv; o_ifft_sample = s_data.
    - in_idx (LGN bits) increments on each accepted sample; sym_in increments when in_idx wraps from N-1.
    - On accepted s_last with in_idx==N-1: sym_in+1, go to FLUSH.
    - On accepted s_last with in_idx!=N-1: pulse o_err_partial, go to PAD.
  - PAD:
    - s_ready=0; o_ifft_ce=adv; o_ifft_sample=0.
    - Continue until in_idx reaches N-1 (inclusive), then sym_in+1 and go to FLUSH.
  - FLUSH:
    - s_ready=0; o_ifft_ce=adv; o_ifft_sample=0.
    - Stay until the output sample carrying m_last is accepted, then go to IDLE.
- Output qualification:
  - pend register is set on any o_ifft_ce and cleared on m_valid&m_ready; with no ce, an un-accepted pend holds.
  - m_valid = pend & (started | i_ifft_sync).
  - started is set on the first accepted output with i_ifft_sync=1 and is cleared in IDLE.
  - If pend=1 while started=0 and i_ifft_sync=0, the cycle's output is pipeline fill: pend is cleared with no m_valid.
- Output counters:
  - out_idx increments per accepted output; sym_out increments on out_idx wrap.
  - m_first = m_valid & (out_idx==0).
  - m_last = m_valid & (out_idx==N-1) & (sym_out==sym_in-1) & (state==FLUSH).
- Since ce is withheld whenever an output is pending unaccepted, no IFFT output is ever overwritten. Throughput is one sample per clock when m_ready=1.
- Symbols beyond 2**SCW-1 per packet are unsupported; the sym_in counter wraps.
- i_abort (any state except IDLE): one-cycle o_ifft_reset, clear pend/started/counters, m_valid=0, go to IDLE. i_abort overrides a simultaneous s_last.
- i_abort in IDLE has no effect.

Decomposition:
- Shared package ifft_pkg:
  - constants LGN, N=64, DW;
  - state enum IDLE/RUN/PAD/FLUSH.
- Sub-module ifft_out_qual: the pend/started/out_idx/sym_out logic producing m_valid, m_first and m_last.

Test Plan:
- One symbol of 64 samples with ramp values, m_ready=1, IFFT instantiated:
  - exactly 64 m_valid beats;
  - m_first on beat 0, m_last on beat 63 only;
  - data matches the reference IFFT model;
  - return to IDLE afterwards, o_busy=0.
- Three back-to-back symbols (192 samples, s_last on 192nd):
  - 192 outputs, no gaps with m_ready=1;
  - m_first at beats 0, 64, 128;
  - single m_last at beat 191.
- s_last on sample 40:
  - o_err_partial pulses once;
  - 24 zero samples are fed in PAD;
  - 64 outputs with m_last at the 64th.
- Random m_ready (50% duty) over two symbols:
  - output sequence identical to the m_ready=1 run;
  - o_ifft_ce never high while m_valid&!m_ready.
- i_abort asserted mid-symbol 2:
  - one-cycle o_ifft_reset, m_valid drops next cycle, state IDLE;
  - a following one-symbol packet produces a clean 64 outputs.
- i_reset_n pulsed low mid-FLUSH: all outputs are immediately at their reset values; a subsequent packet operates normally.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared constants and FSM encoding for the OFDM IFFT packet sequencer.
// Holds the default FFT size, sample width and symbol counter width.
package ifft_pkg;
    localparam int LGN = 6;
    localparam int N   = 1 << LGN;
    localparam int DW  = 16;
    localparam int SCW = 8;

    typedef enum logic [1:0] {IDLE, RUN, PAD, FLUSH} state_t;
endpackage

// File: rtl/ifft_out_qual.sv
// Output qualification for the IFFT result stream: discards pipeline-fill
// outputs, tracks the in-packet output position and flags first/last beats.
module ifft_out_qual
    import ifft_pkg::*;
#(
    parameter int LGN = ifft_pkg::LGN,
    parameter int SCW = ifft_pkg::SCW
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_clr,
    input  logic           i_active,
    input  logic           i_flush,
    input  logic           i_ce,
    input  logic           i_sync,
    input  logic           i_m_ready,
    input  logic [SCW-1:0] i_sym_in,
    output logic           o_m_valid,
    output logic           o_m_first,
    output logic           o_m_last
);
    logic           r_pend;
    logic           r_started;
    logic [LGN-1:0] r_out_idx;
    logic [SCW-1:0] r_sym_out;
    logic           w_acc;
    logic           w_fill;
    logic [SCW-1:0] w_sym_last;

    assign o_m_valid  = r_pend && (r_started || i_sync) && i_active;
    assign w_acc      = o_m_valid && i_m_ready;
    // Outputs ahead of the first sync are leftovers of the pipeline fill.
    assign w_fill     = r_pend && !r_started && !i_sync;
    assign w_sym_last = i_sym_in - SCW'(1);
    assign o_m_first  = o_m_valid && (r_out_idx == '0);
    assign o_m_last   = o_m_valid && (&r_out_idx) && (r_sym_out == w_sym_last) && i_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend    <= 1'b0;
            r_started <= 1'b0;
            r_out_idx <= '0;
            r_sym_out <= '0;
        end else if (i_clr) begin
            r_pend    <= 1'b0;
            r_started <= 1'b0;
            r_out_idx <= '0;
            r_sym_out <= '0;
        end else begin
            if (i_ce)
                r_pend <= 1'b1;
            else if (w_acc || w_fill)
                r_pend <= 1'b0;
            if (w_acc && i_sync)
                r_started <= 1'b1;
            if (w_acc) begin
                r_out_idx <= r_out_idx + 1'b1;
                if (&r_out_idx)
                    r_sym_out <= r_sym_out + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ifft_frame_ctrl.sv
// Packet sequencer around a pipelined IFFT: feeds symbols, zero-pads a short
// final symbol, flushes the pipeline and streams results with global-CE stall.
module ifft_frame_ctrl
    import ifft_pkg::*;
#(
    parameter int LGN = ifft_pkg::LGN,
    parameter int DW  = ifft_pkg::DW,
    parameter int SCW = ifft_pkg::SCW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2*DW-1:0] s_data,
    input  logic          s_last,
    output logic          o_ifft_reset,
    output logic          o_ifft_ce,
    output logic [2*DW-1:0] o_ifft_sample,
    input  logic [2*DW-1:0] i_ifft_result,
    input  logic          i_ifft_sync,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [2*DW-1:0] m_data,
    output logic          m_first,
    output logic          m_last,
    output logic          o_busy,
    output logic          o_err_partial
);
    state_t         r_state;
    logic [LGN-1:0] r_in_idx;
    logic [SCW-1:0] r_sym_in;
    logic           r_err_partial;
    logic           w_idle, w_run, w_pad, w_flush;
    logic           w_adv, w_acc_in, w_in_wrap, w_qual_clr;

    assign w_idle    = (r_state == IDLE);
    assign w_run     = (r_state == RUN);
    assign w_pad     = (r_state == PAD);
    assign w_flush   = (r_state == FLUSH);
    // Hold the whole IFFT while a result waits downstream so none is overwritten.
    assign w_adv     = !m_valid || m_ready;
    assign w_in_wrap = &r_in_idx;

    assign s_ready       = w_run && w_adv && !i_abort;
    assign w_acc_in      = s_valid && s_ready;
    assign o_ifft_ce     = w_acc_in || ((w_pad || w_flush) && w_adv && !i_abort);
    assign o_ifft_sample = w_run ? s_data : '0;
    assign o_ifft_reset  = (w_idle && s_valid) || (!w_idle && i_abort);
    assign o_busy        = !w_idle;
    assign o_err_partial = r_err_partial;
    assign m_data        = i_ifft_result;
    assign w_qual_clr    = w_idle || i_abort;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_in_idx      <= '0;
            r_sym_in      <= '0;
            r_err_partial <= 1'b0;
        end else begin
            r_err_partial <= 1'b0;
            if (!w_idle && i_abort) begin
                r_state  <= IDLE;
                r_in_idx <= '0;
                r_sym_in <= '0;
            end else begin
                case (r_state)
                    IDLE: if (s_valid) begin
                        r_state  <= RUN;
                        r_in_idx <= '0;
                        r_sym_in <= '0;
                    end
                    RUN: if (w_acc_in) begin
                        r_in_idx <= r_in_idx + 1'b1;
                        if (w_in_wrap)
                            r_sym_in <= r_sym_in + 1'b1;
                        if (s_last) begin
                            if (w_in_wrap) begin
                                r_state <= FLUSH;
                            end else begin
                                r_state       <= PAD;
                                r_err_partial <= 1'b1;
                            end
                        end
                    end
                    PAD: if (o_ifft_ce) begin
                        r_in_idx <= r_in_idx + 1'b1;
                        if (w_in_wrap) begin
                            r_sym_in <= r_sym_in + 1'b1;
                            r_state  <= FLUSH;
                        end
                    end
                    FLUSH: if (m_last && m_ready)
                        r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    ifft_out_qual #(.LGN(LGN), .SCW(SCW)) u_qual (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (w_qual_clr),
        .i_active  (!w_idle),
        .i_flush   (w_flush),
        .i_ce      (o_ifft_ce),
        .i_sync    (i_ifft_sync),
        .i_m_ready (m_ready),
        .i_sym_in  (r_sym_in),
        .o_m_valid (m_valid),
        .o_m_first (m_first),
        .o_m_last  (m_last)
    );
endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Scoreboard bench for ifft_frame_ctrl with a CE-gated stand-in IFFT pipeline.
module tb_ifft_frame_ctrl;
    import ifft_pkg::*;

    localparam int SW  = 2 * DW;
    localparam int LAT = 70;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_abort = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          o_ifft_reset, o_ifft_ce;
    logic [SW-1:0] o_ifft_sample;
    logic [SW-1:0] i_ifft_result;
    logic          i_ifft_sync;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [SW-1:0] m_data;
    logic          m_first, m_last, o_busy, o_err_partial;

    always #5 i_clk = ~i_clk;

    ifft_frame_ctrl dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_abort(i_abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .o_ifft_reset(o_ifft_reset), .o_ifft_ce(o_ifft_ce), .o_ifft_sample(o_ifft_sample),
        .i_ifft_result(i_ifft_result), .i_ifft_sync(i_ifft_sync),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_first(m_first), .m_last(m_last), .o_busy(o_busy), .o_err_partial(o_err_partial)
    );

    function automatic logic [SW-1:0] xf(input logic [SW-1:0] x);
        return {x[DW-1:0], x[SW-1:DW]} ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [SW-1:0] smp(input logic [15:0] b, input int k);
        logic [15:0] v;
        v = b + 16'(k);
        return {v, ~v};
    endfunction

    // Stand-in IFFT: fixed CE-step latency, sync tags every N-th input since reset.
    typedef struct packed { logic vld; logic first; logic [SW-1:0] d; } stg_t;
    stg_t        pipe [LAT];
    logic [31:0] f_cnt;
    always @(posedge i_clk) begin
        if (!i_reset_n || o_ifft_reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
            f_cnt <= '0;
        end else if (o_ifft_ce) begin
            pipe[0] <= '{vld: 1'b1, first: (f_cnt[LGN-1:0] == '0), d: xf(o_ifft_sample)};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            f_cnt <= f_cnt + 1;
        end
    end
    assign i_ifft_result = pipe[LAT-1].d;
    assign i_ifft_sync   = pipe[LAT-1].vld && pipe[LAT-1].first;

    typedef struct packed { logic [SW-1:0] d; logic first; logic last; } exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    int   beats = 0, errp_cnt = 0;
    int   cyc = 0, first_cyc = 0, last_cyc = 0;
    logic rdy_rand = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                if (m_valid) begin
                    checks++;
                    if (o_ifft_ce && !m_ready) begin
                        errors++;
                        $display("FAIL ce_stall ce=1 while m_valid=1 m_ready=0 at cycle %0d", cyc);
                    end
                end
                if (o_err_partial) errp_cnt++;
                if (m_valid && m_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got data=%h first=%b last=%b want none", m_data, m_first, m_last);
                    end else begin
                        e = q.pop_front();
                        if ({m_data, m_first, m_last} !== {e.d, e.first, e.last}) begin
                            errors++;
                            $display("FAIL beat%0d got data=%h first=%b last=%b want data=%h first=%b last=%b",
                                     beats, m_data, m_first, m_last, e.d, e.first, e.last);
                        end
                        if (beats == 0) first_cyc = cyc;
                        if (m_last) last_cyc = cyc;
                        beats++;
                    end
                end
            end
        end
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge i_clk);
            #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send(input int nsamp, input logic [15:0] base, input int abort_at);
        int   total, n;
        logic a;
        exp_t e;
        total = ((nsamp + N - 1) / N) * N;
        for (int k = 0; k < total; k++) begin
            e.d     = xf(k < nsamp ? smp(base, k) : '0);
            e.first = (k % N == 0);
            e.last  = (k == total - 1);
            q.push_back(e);
        end
        for (int k = 0; k < nsamp; k++) begin
            s_valid = 1'b1;
            s_data  = smp(base, k);
            s_last  = (k == nsamp - 1);
            if (k == abort_at) begin
                i_abort = 1'b1;
                @(negedge i_clk);
                chk("abort_ifft_reset", 32'(o_ifft_reset), 1);
                @(posedge i_clk); #1;
                i_abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
                @(negedge i_clk);
                chk("abort_m_valid", 32'(m_valid), 0);
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_ifft_reset_once", 32'(o_ifft_reset), 0);
                q.delete();
                return;
            end
            n = 0;
            a = 1'b0;
            while (!a) begin
                @(negedge i_clk);
                a = s_ready;
                @(posedge i_clk); #1;
                n++;
                if (!a && n > 1000) begin
                    chk("s_ready_timeout", 32'(n), 0);
                    s_valid = 1'b0; s_last = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        chk({nm, "_busy"}, 32'(o_busy), 0);
        chk({nm, "_q_left"}, 32'(q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        fork
            monitor();
            rdy_drv();
        join_none

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_ce", 32'(o_ifft_ce), 0);
        chk("rst_ifft_reset", 32'(o_ifft_reset), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_first", 32'(m_first), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_err", 32'(o_err_partial), 0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        beats = 0;
        send(64, 16'h0100, -1);
        wait_idle("one_sym");
        chk("one_sym_beats", 32'(beats), 64);
        chk("one_sym_span", 32'(last_cyc - first_cyc), 63);
        chk("one_sym_no_err", 32'(errp_cnt), 0);

        beats = 0;
        send(192, 16'h2000, -1);
        wait_idle("three_sym");
        chk("three_sym_beats", 32'(beats), 192);
        chk("three_sym_span", 32'(last_cyc - first_cyc), 191);

        beats = 0;
        e0 = errp_cnt;
        send(40, 16'h3000, -1);
        wait_idle("partial");
        chk("partial_beats", 32'(beats), 64);
        chk("partial_err_pulses", 32'(errp_cnt - e0), 1);

        beats = 0;
        rdy_rand = 1'b1;
        send(128, 16'h0100, -1);
        wait_idle("rand_rdy");
        chk("rand_rdy_beats", 32'(beats), 128);
        rdy_rand = 1'b0;

        send(192, 16'h4000, 100);
        beats = 0;
        send(64, 16'h5000, -1);
        wait_idle("post_abort");
        chk("post_abort_beats", 32'(beats), 64);

        send(64, 16'h6000, -1);
        repeat (20) @(posedge i_clk);
        #1;
        chk("flush_busy", 32'(o_busy), 1);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        chk("mid_rst_ce", 32'(o_ifft_ce), 0);
        chk("mid_rst_ifft_reset", 32'(o_ifft_reset), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_first", 32'(m_first), 0);
        chk("mid_rst_m_last", 32'(m_last), 0);
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_err", 32'(o_err_partial), 0);
        q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        beats = 0;
        send(64, 16'h7000, -1);
        wait_idle("post_rst");
        chk("post_rst_beats", 32'(beats), 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
